// File: rtl/toggle_meter_pkg.sv
// toggle_meter shared types and default parameters.
// Optional debounce selected by TOGGLE_METER_DEBOUNCE_EN.
package toggle_meter_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_RISE,
    MEAS_HIGH,
    MEAS_LOW,
    REPORT
  } state_t;

  localparam int CNT_W_DEF       = 16;
  localparam int SYNC_STAGES_DEF = 2;

endpackage

// File: rtl/toggle_sync.sv
// q0 synchroniser with registered rise/fall pulses.
// TOGGLE_METER_DEBOUNCE_EN adds a 2-cycle level qualifier.
module toggle_sync
  import toggle_meter_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic clk0,
  input  logic rst0,
  input  logic q0,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sr;
  logic                   s;
  logic                   p;

  assign s = sr[SYNC_STAGES-1];

`ifdef TOGGLE_METER_DEBOUNCE_EN
  logic lvl;

  // lvl is the accepted level; it moves only when s and p agree
  always_ff @(posedge clk0 or posedge rst0) begin
    if (rst0) begin
      sr   <= '0;
      p    <= 1'b0;
      lvl  <= 1'b0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      sr   <= {sr[SYNC_STAGES-2:0], q0};
      p    <= s;
      rise <= s & p & ~lvl;
      fall <= ~s & ~p & lvl;
      if (s == p)
        lvl <= s;
    end
  end
`else
  always_ff @(posedge clk0 or posedge rst0) begin
    if (rst0) begin
      sr   <= '0;
      p    <= 1'b0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      sr   <= {sr[SYNC_STAGES-2:0], q0};
      p    <= s;
      rise <= s & ~p;
      fall <= ~s & p;
    end
  end
`endif

endmodule

// File: rtl/toggle_meter.sv
// Measures one high and one low phase of q0 in clk0 cycles.
// Build option: TOGGLE_METER_DEBOUNCE_EN (see toggle_sync).
module toggle_meter
  import toggle_meter_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic             clk0,
  input  logic             rst0,
  input  logic             q0,
  input  logic             en0,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [CNT_W-1:0] high_cnt,
  output logic [CNT_W-1:0] low_cnt,
  output logic             ovf
);

  localparam logic [CNT_W-1:0] CMAX = '1;
  localparam logic [CNT_W-1:0] ONE  = 1;

  state_t           state;
  state_t           state_n;
  logic             rise;
  logic             fall;
  logic [CNT_W-1:0] hc;
  logic [CNT_W-1:0] lc;
  logic             hs;
  logic             ls;

  toggle_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk0(clk0),
    .rst0(rst0),
    .q0  (q0),
    .rise(rise),
    .fall(fall)
  );

  always_ff @(posedge clk0 or posedge rst0) begin
    if (rst0)
      state <= IDLE;
    else
      state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:
        if (en0) state_n = WAIT_RISE;
      WAIT_RISE:
        if (!en0)     state_n = IDLE;
        else if (rise) state_n = MEAS_HIGH;
      MEAS_HIGH:
        if (!en0)     state_n = IDLE;
        else if (fall) state_n = MEAS_LOW;
      MEAS_LOW:
        if (!en0)     state_n = IDLE;
        else if (rise) state_n = REPORT;
      REPORT:
        if (m_ready)
          state_n = en0 ? WAIT_RISE : IDLE;
      default:
        state_n = IDLE;
    endcase
  end

  assign m_valid = (state == REPORT);

  // hs/ls record a blocked increment, i.e. cycles were lost
  always_ff @(posedge clk0 or posedge rst0) begin
    if (rst0) begin
      hc       <= '0;
      lc       <= '0;
      hs       <= 1'b0;
      ls       <= 1'b0;
      high_cnt <= '0;
      low_cnt  <= '0;
      ovf      <= 1'b0;
    end else begin
      unique case (1'b1)
        state_n == IDLE: begin
          hc <= '0;
          lc <= '0;
          hs <= 1'b0;
          ls <= 1'b0;
        end
        state == WAIT_RISE && state_n == MEAS_HIGH: begin
          hc <= ONE;
          hs <= 1'b0;
        end
        state == MEAS_HIGH && state_n == MEAS_HIGH: begin
          if (hc == CMAX) hs <= 1'b1;
          else            hc <= hc + ONE;
        end
        state == MEAS_HIGH && state_n == MEAS_LOW: begin
          lc <= ONE;
          ls <= 1'b0;
        end
        state == MEAS_LOW && state_n == MEAS_LOW: begin
          if (lc == CMAX) ls <= 1'b1;
          else            lc <= lc + ONE;
        end
        state == MEAS_LOW && state_n == REPORT: begin
          high_cnt <= hc;
          low_cnt  <= lc;
          ovf      <= hs | ls;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_toggle_meter.sv
// Self-checking bench for toggle_meter (16-bit and 4-bit instances).
module tb_toggle_meter;
  import toggle_meter_pkg::*;

  localparam int SYNC = 2;
`ifdef TOGGLE_METER_DEBOUNCE_EN
  localparam int LAT = SYNC + 3;
`else
  localparam int LAT = SYNC + 2;
`endif

  logic        clk0;
  logic        rst0;
  logic        q0;
  logic        en0;
  logic        m_ready;
  logic        v0, v1;
  logic [15:0] h0, l0;
  logic [3:0]  h1, l1;
  logic        o0, o1;

  int checks = 0;
  int errors = 0;

  toggle_meter #(.CNT_W(16), .SYNC_STAGES(SYNC)) u0 (
    .clk0(clk0), .rst0(rst0), .q0(q0), .en0(en0),
    .m_valid(v0), .m_ready(m_ready),
    .high_cnt(h0), .low_cnt(l0), .ovf(o0)
  );

  toggle_meter #(.CNT_W(4), .SYNC_STAGES(SYNC)) u1 (
    .clk0(clk0), .rst0(rst0), .q0(q0), .en0(en0),
    .m_valid(v1), .m_ready(m_ready),
    .high_cnt(h1), .low_cnt(l1), .ovf(o1)
  );

  initial clk0 = 1'b0;
  always #5 clk0 = ~clk0;

  typedef struct {
    int h;
    int l;
    int hold;
    int e0h, e0l, e0o;
    int e1h, e1l, e1o;
  } vec_t;

  task automatic tick();
    @(posedge clk0);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input int h, input int l);
    q0 = 1'b0;
    repeat (8) tick();
    q0 = 1'b1;
    repeat (h) tick();
    q0 = 1'b0;
    repeat (l) tick();
    q0 = 1'b1;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!v0 && n < 40) begin
      tick();
      n++;
    end
  endtask

  task automatic run_meas(input vec_t t);
    int n;
    int bad;
    logic [15:0] sh, sl;
    m_ready = (t.hold == 0);
    drive(t.h, t.l);
    wait_valid(n);
    chk("latency", n, LAT);
    chk("u0.high", int'(h0), t.e0h);
    chk("u0.low", int'(l0), t.e0l);
    chk("u0.ovf", int'(o0), t.e0o);
    chk("u1.valid", int'(v1), 1);
    chk("u1.high", int'(h1), t.e1h);
    chk("u1.low", int'(l1), t.e1l);
    chk("u1.ovf", int'(o1), t.e1o);
    if (t.hold > 0) begin
      bad = 0;
      sh = h0;
      sl = l0;
      for (int i = 0; i < t.hold; i++) begin
        tick();
        if (!v0 || h0 != sh || l0 != sl) bad++;
      end
      chk("hold_stable", bad, 0);
      m_ready = 1'b1;
    end
    tick();
    chk("valid_drop", int'(v0), 0);
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (v0) bad++;
    end
    chk("single_result", bad, 0);
  endtask

  function automatic vec_t model(input int h, input int l);
    vec_t t;
    t.h = h;
    t.l = l;
    t.hold = 0;
    t.e0h = h;
    t.e0l = l;
    t.e0o = 0;
    t.e1h = (h > 15) ? 15 : h;
    t.e1l = (l > 15) ? 15 : l;
    t.e1o = (h > 15 || l > 15) ? 1 : 0;
    return t;
  endfunction

  vec_t tab[$];

  initial begin
    int n;
    int got;
    int bad;
    rst0 = 1'b1;
    q0 = 1'b0;
    en0 = 1'b0;
    m_ready = 1'b1;

    tab.push_back('{5, 3, 10, 5, 3, 0, 5, 3, 0});
    tab.push_back('{2, 7, 0, 2, 7, 0, 2, 7, 0});
    tab.push_back('{20, 2, 0, 20, 2, 0, 15, 2, 1});
    tab.push_back('{15, 15, 0, 15, 15, 0, 15, 15, 0});
    tab.push_back('{16, 3, 0, 16, 3, 0, 15, 3, 1});
    tab.push_back('{3, 17, 0, 3, 17, 0, 3, 15, 1});

    repeat (3) tick();
    chk("rst.valid", int'(v0), 0);
    chk("rst.high", int'(h0), 0);
    chk("rst.low", int'(l0), 0);
    chk("rst.ovf", int'(o0), 0);
    rst0 = 1'b0;
    tick();
    chk("idle_no_en", int'(u0.state), int'(IDLE));
    en0 = 1'b1;

    foreach (tab[i]) run_meas(tab[i]);

    for (int i = 0; i < 8; i++)
      run_meas(model($urandom_range(40, 2), $urandom_range(40, 2)));

`ifndef TOGGLE_METER_DEBOUNCE_EN
    q0 = 1'b0;
    repeat (8) tick();
    got = 0;
    bad = 0;
    for (int i = 0; i < 60; i++) begin
      q0 = ~q0;
      tick();
      if (v0) begin
        got++;
        if (h0 != 16'd1 || l0 != 16'd1 || o0) bad++;
      end
    end
    chk("tff.results_ok", bad, 0);
    chk("tff.have_results", int'(got >= 3), 1);
    q0 = 1'b0;
    repeat (8) tick();
`endif

    q0 = 1'b0;
    repeat (8) tick();
    q0 = 1'b1;
    repeat (4) tick();
    q0 = 1'b0;
    repeat (6) tick();
    chk("abort.in_low", int'(u0.state), int'(MEAS_LOW));
    en0 = 1'b0;
    tick();
    chk("abort.idle", int'(u0.state), int'(IDLE));
    q0 = 1'b1;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (v0) bad++;
    end
    chk("abort.no_valid", bad, 0);
    en0 = 1'b1;
    run_meas(model(4, 4));

    m_ready = 1'b0;
    drive(6, 5);
    wait_valid(n);
    chk("rst_mid.valid_before", int'(v0), 1);
    #2;
    rst0 = 1'b1;
    #1;
    chk("rst_mid.valid", int'(v0), 0);
    chk("rst_mid.high", int'(h0), 0);
    chk("rst_mid.low", int'(l0), 0);
    chk("rst_mid.u1high", int'(h1), 0);
    #1;
    rst0 = 1'b0;
    m_ready = 1'b1;
    repeat (2) tick();
    chk("rst_mid.restart", int'(u0.state), int'(WAIT_RISE));

`ifdef TOGGLE_METER_DEBOUNCE_EN
    q0 = 1'b0;
    repeat (8) tick();
    q0 = 1'b1;
    repeat (4) tick();
    q0 = 1'b0;
    repeat (3) tick();
    q0 = 1'b1;
    tick();
    q0 = 1'b0;
    repeat (2) tick();
    q0 = 1'b1;
    wait_valid(n);
    chk("glitch.valid", int'(v0), 1);
    chk("glitch.high", int'(h0), 4);
    chk("glitch.low", int'(l0), 6);
    tick();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/toggle_meter.md
TOGGLE_METER -- requirements
Module: toggle_meter

Interface
REQ-001 SHALL have parameter CNT_W, default 16: width of high/low cycle counters (range 4..32).
REQ-002 SHALL have parameter SYNC_STAGES, default 2: flip-flop stages on q0 before edge detection (range 2..4).
REQ-003 SHALL have port clk0  input  1: single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst0  input  1: reset, asynchronous and active-high.
REQ-005 SHALL have port q0  input  1: toggle flip-flop output under measurement, may be asynchronous to clk0.
REQ-006 SHALL have port en0  input  1: measurement enable.
REQ-007 SHALL have port m_valid  output  1: result available.
REQ-008 SHALL have port m_ready  input  1: consumer accepts result.
REQ-009 SHALL have port high_cnt  output  CNT_W: clk0 cycles q0 was high.
REQ-010 SHALL have port low_cnt  output  CNT_W: clk0 cycles q0 was low.
REQ-011 SHALL have port ovf  output  1: either count saturated in the reported result.

Function
REQ-012 SHALL pass q0 through SYNC_STAGES flops to give s, keep previous sample p; rise = s & ~p, fall = ~s & p.
REQ-013 SHALL implement FSM states IDLE, WAIT_RISE, MEAS_HIGH, MEAS_LOW, REPORT.
REQ-014 IDLE -> WAIT_RISE when en0=1; WAIT_RISE -> MEAS_HIGH on rise, high counter loaded with 1.
REQ-015 MEAS_HIGH: high counter +1 per cycle; on fall -> MEAS_LOW, low counter loaded with 1.
REQ-016 MEAS_LOW: low counter +1 per cycle; on rise -> REPORT, counters copied to high_cnt/low_cnt.
REQ-017 For q0 stable high H cycles then low L cycles, result SHALL be high_cnt=H, low_cnt=L.
REQ-018 m_valid SHALL assert the cycle after the closing rise is detected (SYNC_STAGES+2 cycles after q0 rises).
REQ-019 REPORT: m_valid, high_cnt, low_cnt, ovf SHALL hold stable until m_valid & m_ready.
REQ-020 On handshake: en0=1 -> WAIT_RISE, en0=0 -> IDLE; m_valid deasserts next cycle.
REQ-021 Counters SHALL saturate at 2^CNT_W-1 (no wrap); saturation in either sets ovf for that result.
REQ-022 en0=0 in WAIT_RISE/MEAS_HIGH/MEAS_LOW SHALL abort to IDLE next cycle, partial counts discarded, m_valid stays 0.
REQ-023 en0=0 in REPORT SHALL NOT drop the pending result.
REQ-024 Edges during REPORT SHALL be ignored; next measurement starts at the first rise after WAIT_RISE entry.

Reset
REQ-025 rst0=1 SHALL immediately force IDLE, sync flops and p to 0, counters 0.
REQ-026 Reset values: m_valid=0, high_cnt=0, low_cnt=0, ovf=0; reset mid-measurement or mid-REPORT discards all state.

Configuration
REQ-027 Macro TOGGLE_METER_DEBOUNCE_EN SHALL select debounce.
REQ-028 Defined: an edge is accepted only after s holds its new level for 2 consecutive cycles; pulses shorter than 2 cycles ignored; REQ-018 latency +1 cycle; REQ-017 holds for H,L >= 2.
REQ-029 Undefined: edges taken directly per REQ-012; H,L >= 1 measurable.

Structure
REQ-030 Package toggle_meter_pkg SHALL hold the FSM state enumeration typedef and SYNC_STAGES/CNT_W defaults.
REQ-031 Sub-module toggle_sync SHALL implement the synchroniser plus edge detector (and debounce when enabled).

Verification
REQ-032 q0 driven by a TFF with t0=1 every cycle (H=1,L=1), en0=1, m_ready=1 -> high_cnt=1, low_cnt=1, ovf=0 (macro undefined).
REQ-033 q0 high 5, low 3 cycles, m_ready=0 for 10 cycles after m_valid -> outputs hold 5/3 stable until m_ready=1, one result accepted.
REQ-034 CNT_W=4, q0 high 20 cycles, low 2 -> high_cnt=15, low_cnt=2, ovf=1.
REQ-035 en0 dropped in MEAS_LOW -> m_valid never asserts, FSM in IDLE next cycle; re-enable, H=4,L=4 -> 4/4.
REQ-036 rst0 pulsed mid-REPORT asynchronously -> m_valid=0, counts=0 before next clk0 edge.
REQ-037 Macro defined, 1-cycle glitch high inside low phase L=6 -> glitch ignored, low_cnt=6.
